// File: rtl/asrv32_imem_responder.sv
// Instruction memory responder for the asrv32 fetch stage.
// Single read/write port word memory with optional wait states and fault reporting.
module asrv32_imem_responder #(
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] MEM_BASE    = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stb_inst,
  input  logic [31:0] i_inst_addr,
  output logic [31:0] o_inst,
  output logic        o_ack_inst,
  output logic        o_err_inst,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_addr,
  input  logic [31:0] i_wr_data,
  input  logic [3:0]  i_wr_be
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [2:0] WS_LOAD =
    (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  state_t      state_nx;
  logic [2:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] inst_q;
  logic        err_q;
  logic [31:0] mem [MEM_DEPTH];

  logic          accept;
  logic          load;
  logic          rd_fault;
  logic          wr_ok;
  logic [31:0]   rd_addr;
  logic [31:0]   rd_off;
  logic [31:0]   wr_off;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;

  // While waiting, the read uses the address captured at acceptance.
  assign accept   = i_stb_inst && (state != WAIT);
  assign load     = (state == WAIT) ? (i_stb_inst && cnt == 3'd0)
                                    : (accept && WAIT_STATES == 0);
  assign rd_addr  = (state == WAIT) ? addr_q : i_inst_addr;
  assign rd_off   = rd_addr - MEM_BASE;
  assign rd_idx   = rd_off[AW+1:2];
  assign rd_fault = (rd_addr[1:0] != 2'b00) || ((rd_off >> 2) >= MEM_DEPTH);
  assign wr_off   = i_wr_addr - MEM_BASE;
  assign wr_idx   = wr_off[AW+1:2];
  assign wr_ok    = (wr_off >> 2) < MEM_DEPTH;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, RESP: begin
        if (!i_stb_inst)           state_nx = IDLE;
        else if (WAIT_STATES == 0) state_nx = RESP;
        else                       state_nx = WAIT;
      end
      WAIT: begin
        if (!i_stb_inst)        state_nx = IDLE;
        else if (cnt == 3'd0)   state_nx = RESP;
        else                    state_nx = WAIT;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_inst     = inst_q;
    o_ack_inst = (state == RESP);
    o_err_inst = (state == RESP) && err_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt    <= 3'd0;
      addr_q <= 32'd0;
      inst_q <= 32'd0;
      err_q  <= 1'b0;
    end else begin
      if (accept) addr_q <= i_inst_addr;
      if (accept)
        cnt <= WS_LOAD;
      else if (state == WAIT && cnt != 3'd0)
        cnt <= cnt - 3'd1;
      else
        cnt <= 3'd0;
      if (load) begin
        inst_q <= rd_fault ? NOP : mem[rd_idx];
        err_q  <= rd_fault;
      end
    end
  end

  // Contents survive reset; only the write itself is gated.
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_wr_en && wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wr_be[b]) mem[wr_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_asrv32_imem_responder.sv
// Scoreboard bench for asrv32_imem_responder: zero-wait and three-wait instances
// share one stimulus stream and are checked against a transaction-level model.
module tb_asrv32_imem_responder;

  localparam int DEPTH = 16;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic [31:0] addr = 32'd0;
  logic        wr_en = 1'b0;
  logic [31:0] waddr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  be = 4'd0;
  logic [31:0] inst [2];
  logic        ack [2];
  logic        err [2];

  always #5 clk = ~clk;

  asrv32_imem_responder #(
    .MEM_DEPTH(DEPTH), .WAIT_STATES(0), .MEM_BASE(BASE)
  ) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_stb_inst(stb), .i_inst_addr(addr),
    .o_inst(inst[0]), .o_ack_inst(ack[0]), .o_err_inst(err[0]),
    .i_wr_en(wr_en), .i_wr_addr(waddr), .i_wr_data(wdata), .i_wr_be(be)
  );

  asrv32_imem_responder #(
    .MEM_DEPTH(DEPTH), .WAIT_STATES(3), .MEM_BASE(BASE)
  ) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_stb_inst(stb), .i_inst_addr(addr),
    .o_inst(inst[1]), .o_ack_inst(ack[1]), .o_err_inst(err[1]),
    .i_wr_en(wr_en), .i_wr_addr(waddr), .i_wr_data(wdata), .i_wr_be(be)
  );

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        q [2][$];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] last [2];
  int          ws [2] = '{0, 3};
  bit          pend_v [2];
  logic [31:0] pend_a [2];
  int          pend_n [2];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always @(posedge clk) cyc++;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, act, exp);
    end
  endtask

  // Fetch result as seen at read time: fault rules, then model memory.
  function automatic void expect_fetch(int d, logic [31:0] a, int c);
    logic [31:0] off;
    logic        f;
    exp_t        e;
    off = a - BASE;
    f = (a[1:0] != 2'b00) || ((off >> 2) >= DEPTH);
    e.cyc = c;
    e.err = f;
    e.data = f ? 32'h0000_0013 : mem_m[int'(off >> 2)];
    q[d].push_back(e);
  endfunction

  // Applies the inputs about to be sampled at the next rising edge.
  function automatic void model();
    logic [31:0] off;
    int c;
    c = cyc + 1;
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        pend_v[d] = 1'b0;
        last[d] = 32'd0;
      end
      return;
    end
    for (int d = 0; d < 2; d++) begin
      if (pend_v[d]) begin
        if (!stb) pend_v[d] = 1'b0;
        else begin
          pend_n[d]--;
          if (pend_n[d] == 0) begin
            expect_fetch(d, pend_a[d], c);
            pend_v[d] = 1'b0;
          end
        end
      end else if (stb) begin
        if (ws[d] == 0) expect_fetch(d, addr, c);
        else begin
          pend_v[d] = 1'b1;
          pend_a[d] = addr;
          pend_n[d] = ws[d];
        end
      end
    end
    if (wr_en) begin
      off = waddr - BASE;
      if ((off >> 2) < DEPTH) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mem_m[int'(off >> 2)][8*b +: 8] = wdata[8*b +: 8];
      end
    end
  endfunction

  task automatic step(input bit r, input bit s, input logic [31:0] a,
                      input bit w, input logic [31:0] wa,
                      input logic [31:0] wd, input logic [3:0] b);
    @(negedge clk);
    #1;
    rst = r; stb = s; addr = a;
    wr_en = w; waddr = wa; wdata = wd; be = b;
    model();
  endtask

  task automatic fetch(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) step(0, 1, a, 0, 0, 0, 4'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 4'h0);
  endtask

  function automatic logic [31:0] rnd_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return BASE + $urandom_range(0, DEPTH * 4 + 8);
    if (k == 1) return $urandom;
    return BASE + 4 * $urandom_range(0, DEPTH - 1);
  endfunction

  exp_t me;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ack[d] === 1'b1) begin
        if (q[d].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack_d%0d cyc=%0d got=%h exp=none",
                   d, cyc, inst[d]);
        end else begin
          me = q[d].pop_front();
          chk($sformatf("ack_cycle_d%0d", d), cyc, me.cyc);
          chk($sformatf("inst_d%0d", d), inst[d], me.data);
          chk($sformatf("err_d%0d", d), {31'd0, err[d]}, {31'd0, me.err});
          last[d] = me.data;
        end
      end else begin
        if (q[d].size() > 0 && q[d][0].cyc <= cyc) begin
          me = q[d].pop_front();
          checks++;
          failures++;
          $display("FAIL missing_ack_d%0d cyc=%0d got=none exp=%h",
                   d, cyc, me.data);
        end
        chk($sformatf("hold_inst_d%0d", d), inst[d], last[d]);
        chk($sformatf("err_noack_d%0d", d), {31'd0, err[d]}, 32'd0);
      end
    end
  end

  initial begin
    last[0] = 32'd0;
    last[1] = 32'd0;
    pend_v[0] = 1'b0;
    pend_v[1] = 1'b0;
    step(1, 1, BASE, 0, 0, 0, 4'h0);
    step(1, 1, BASE, 0, 0, 0, 4'h0);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_inst_d%0d", d), inst[d], 32'd0);
      chk($sformatf("rst_ack_d%0d", d), {31'd0, ack[d]}, 32'd0);
    end
    idle(2);
    for (int i = 0; i < DEPTH; i++)
      step(0, 0, 0, 1, BASE + 4 * i,
           (i < 4) ? 32'hA0 + i : $urandom, 4'hF);
    // Back-to-back stream
    fetch(BASE + 0, 1);
    fetch(BASE + 4, 1);
    fetch(BASE + 8, 1);
    fetch(BASE + 12, 1);
    idle(5);
    // Single waited fetch
    fetch(BASE + 8, 4);
    idle(6);
    // Abort in first wait cycle, then a normal fetch
    fetch(BASE + 4, 1);
    idle(2);
    fetch(BASE + 4, 4);
    idle(5);
    // Faults: misaligned, one past the end, below the base
    fetch(BASE + 6, 4);
    idle(5);
    fetch(BASE + 4 * DEPTH, 4);
    idle(5);
    fetch(BASE - 4, 4);
    idle(5);
    // Read-first collision with a partial-byte write
    step(0, 0, 0, 1, BASE + 20, 32'hFFFF_FFFF, 4'hF);
    step(0, 1, BASE + 20, 1, BASE + 22, 32'h1122_3344, 4'b0101);
    fetch(BASE + 20, 3);
    idle(5);
    fetch(BASE + 20, 4);
    idle(5);
    for (int i = 0; i < 400; i++)
      step(0, ($urandom_range(0, 9) < 8), rnd_addr(),
           ($urandom_range(0, 2) == 0), rnd_addr(), $urandom,
           4'($urandom_range(0, 15)));
    idle(6);
    // Reset while the waited instance is mid-request
    fetch(BASE + 12, 2);
    step(1, 1, BASE + 12, 1, BASE + 28, 32'hDEAD_BEEF, 4'hF);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("async_rst_inst_d%0d", d), inst[d], 32'd0);
      chk($sformatf("async_rst_ack_d%0d", d), {31'd0, ack[d]}, 32'd0);
      chk($sformatf("async_rst_err_d%0d", d), {31'd0, err[d]}, 32'd0);
    end
    step(1, 0, 0, 1, BASE + 28, 32'hDEAD_BEEF, 4'hF);
    idle(6);
    fetch(BASE + 28, 4);
    idle(5);
    fetch(BASE + 12, 4);
    idle(6);
    for (int d = 0; d < 2; d++)
      chk($sformatf("drain_d%0d", d), q[d].size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/asrv32_imem_responder.md
ASRV32_IMEM_RESPONDER -- requirements
Module: asrv32_imem_responder

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1024, number of 32-bit words stored (power of two, 16..65536).
REQ-002 SHALL have parameter WAIT_STATES, default 0, extra response cycles per fetch (0..7).
REQ-003 SHALL have parameter MEM_BASE, default 32'h0000_0000, byte address of word 0.
REQ-004 SHALL have one clock and an asynchronous active-high reset, with ports listed below.
REQ-005 SHALL have port i_clk  input  1  clock, all state updates on the rising edge.
REQ-006 SHALL have port i_rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have port i_stb_inst  input  1  fetch request strobe from the fetch stage.
REQ-008 SHALL have port i_inst_addr  input  32  fetch byte address.
REQ-009 SHALL have port o_inst  output  32  instruction returned.
REQ-010 SHALL have port o_ack_inst  output  1  one-cycle pulse, o_inst valid.
REQ-011 SHALL have port o_err_inst  output  1  fetch fault, asserted only together with o_ack_inst.
REQ-012 SHALL have port i_wr_en  input  1  preload/store write enable.
REQ-013 SHALL have port i_wr_addr  input  32  write byte address.
REQ-014 SHALL have port i_wr_data  input  32  write data.
REQ-015 SHALL have port i_wr_be  input  4  byte enables, bit n writes byte n.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP, all registered.
REQ-017 SHALL accept a request at a rising edge when i_stb_inst=1 and the state is IDLE or RESP, sampling i_inst_addr at that edge.
REQ-018 On acceptance with WAIT_STATES=0, SHALL go to RESP; otherwise SHALL go to WAIT, loading a 3-bit counter with WAIT_STATES-1.
REQ-019 In WAIT, SHALL decrement the counter each cycle and go to RESP after the cycle in which the counter equals 0.
REQ-020 SHALL assert o_ack_inst only in RESP, so the ack for a request accepted at edge N is visible in the cycle after edge N+WAIT_STATES.
REQ-021 In RESP with i_stb_inst=0, SHALL go to IDLE; with i_stb_inst=1, SHALL accept a new request (REQ-017).
REQ-022 With WAIT_STATES=0 and i_stb_inst held high, SHALL ack every cycle: one instruction per clock, each for the address sampled one edge earlier.
REQ-023 If i_stb_inst=0 in any WAIT cycle, SHALL abort: return to IDLE at the next edge with no ack for that request.
REQ-024 SHALL hold o_inst stable from an ack until the next ack.
REQ-025 SHALL compute the word index as (addr-MEM_BASE)>>2, using modulo-2^32 subtraction.
REQ-026 SHALL treat a fetch as faulted when addr[1:0]!=0 or the word index is >= MEM_DEPTH.
REQ-027 On a faulted fetch, SHALL return o_inst=32'h0000_0013 (NOP) with o_err_inst=1 in the ack cycle.
REQ-028 SHALL write bytes selected by i_wr_be at every edge where i_wr_en=1 and the word index is in range, independent of FSM state.
REQ-029 SHALL ignore write addr[1:0].
REQ-030 SHALL silently drop out-of-range writes.
REQ-031 For a write and a read acceptance of the same word at the same edge, SHALL return the old data (read-first).
REQ-032 A write to a word already accepted but still in WAIT SHALL be visible in that fetch's response.
REQ-033 SHALL use a single read port and a single write port; the read SHALL be performed at the edge that enters RESP.

Reset
REQ-034 While i_rst=1, SHALL hold state IDLE, o_ack_inst=0, o_err_inst=0, o_inst=32'h0000_0000, and the wait counter at 0.
REQ-035 SHALL NOT reset memory contents.
REQ-036 Reset asserted mid-request SHALL discard the request; no ack SHALL follow reset release until a new acceptance.
REQ-037 SHALL ignore writes while i_rst=1.

Verification
REQ-038 Preload words 0..3 = 0xA0..0xA3, WAIT_STATES=0, stb high, addresses 0,4,8,12 on consecutive edges -> acks on 4 consecutive cycles with o_inst A0,A1,A2,A3 and err=0.
REQ-039 WAIT_STATES=3, single fetch of addr 8 -> ack in the 4th cycle after acceptance with o_inst=word 2, and o_inst unchanged afterwards.
REQ-040 WAIT_STATES=2, stb dropped in the first WAIT cycle -> no ack, state IDLE; next fetch of addr 4 is acked normally.
REQ-041 Fetch addr 0x6 and fetch addr MEM_BASE+4*MEM_DEPTH -> each acked with o_inst=0x0000_0013 and o_err_inst=1.
REQ-042 Write word 5 = 0x11223344 with be=4'b0101 over 0xFFFF_FFFF at the same edge as a fetch of addr 20 -> fetch returns 0xFFFF_FFFF; the next fetch returns 0xFF22FF44.
REQ-043 Assert i_rst in the WAIT state -> outputs immediately take reset values; no ack after release; memory retains its contents.
